// File: rtl/axil_pkg.sv
// AXI-Lite definitions shared by the UDP bridge and its downstream slaves.
package axil_pkg;

  localparam int AXIL_ADDR_WIDTH = 32;
  localparam int AXIL_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axil_write_joiner.sv
// Pairs independently arriving AW and W beats into one write commit,
// holding whichever arrives first in a one-entry slot.
module axil_write_joiner
  import axil_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         resp_pending,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [AXIL_ADDR_WIDTH-3:0]   aw_word_addr,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [AXIL_DATA_WIDTH-1:0]   wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  output logic                         accept,
  output logic                         commit,
  output logic [AXIL_ADDR_WIDTH-3:0]   commit_word_addr,
  output logic [AXIL_DATA_WIDTH-1:0]   commit_data,
  output logic [AXIL_DATA_WIDTH/8-1:0] commit_strb
);

  logic                         aw_held;
  logic                         w_held;
  logic [AXIL_ADDR_WIDTH-3:0]   aw_addr_q;
  logic [AXIL_DATA_WIDTH-1:0]   w_data_q;
  logic [AXIL_DATA_WIDTH/8-1:0] w_strb_q;
  logic                         aw_hs;
  logic                         w_hs;

  // Ready is held low in reset and while a B response is outstanding.
  assign awready = reset_n && !aw_held && !resp_pending;
  assign wready  = reset_n && !w_held && !resp_pending;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign accept  = aw_hs || w_hs;

  // Both halves are present now, whether from a slot or this cycle's handshake.
  assign commit           = (aw_held || aw_hs) && (w_held || w_hs);
  assign commit_word_addr = aw_held ? aw_addr_q : aw_word_addr;
  assign commit_data      = w_held ? w_data_q : wdata;
  assign commit_strb      = w_held ? w_strb_q : wstrb;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within or across blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= aw_word_addr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_register_bank.sv
// AXI-Lite slave exposing REG_COUNT 32-bit registers: writable control
// registers driven to fabric and read-only status registers sampled from it.
module axil_register_bank
  import axil_pkg::*;
#(
  parameter int                   REG_COUNT   = 16,
  parameter logic [31:0]          BASE_ADDR   = 32'h0000_0000,
  parameter logic [REG_COUNT-1:0] RO_MASK     = '0,
  parameter logic [31:0]          RESET_VALUE = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   axil_awaddr,
  input  logic                          axil_awvalid,
  output logic                          axil_awready,
  input  logic [31:0]                   axil_wdata,
  input  logic [3:0]                    axil_wstrb,
  input  logic                          axil_wvalid,
  output logic                          axil_wready,
  output logic [1:0]                    axil_bresp,
  output logic                          axil_bvalid,
  input  logic                          axil_bready,
  input  logic [31:0]                   axil_araddr,
  input  logic                          axil_arvalid,
  output logic                          axil_arready,
  output logic [31:0]                   axil_rdata,
  output logic [1:0]                    axil_rresp,
  output logic                          axil_rvalid,
  input  logic                          axil_rready,
  output logic [REG_COUNT-1:0][31:0]    ctrl_out,
  input  logic [REG_COUNT-1:0][31:0]    status_in,
  output logic                          wr_pulse,
  output logic [$clog2(REG_COUNT)-1:0]  wr_index
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int TAG_W = AXIL_ADDR_WIDTH - 2 - IDX_W;
  localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[AXIL_ADDR_WIDTH-1 -: TAG_W];

  typedef enum logic [1:0] {WR_IDLE, WR_PARTIAL, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t                   wr_state;
  rd_state_t                   rd_state;
  resp_t                       bresp_q;
  resp_t                       rresp_q;
  logic [31:0]                 rdata_q;
  logic [REG_COUNT-1:0][31:0]  ctrl_q;

  logic                        accept;
  logic                        commit;
  logic [AXIL_ADDR_WIDTH-3:0]  commit_word_addr;
  logic [31:0]                 commit_data;
  logic [3:0]                  commit_strb;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_hit;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_hit;
  logic                        unused_addr_lsbs;

  axil_write_joiner u_joiner (
    .clk              (clk),
    .reset_n          (reset_n),
    .resp_pending     (axil_bvalid),
    .awvalid          (axil_awvalid),
    .awready          (axil_awready),
    .aw_word_addr     (axil_awaddr[AXIL_ADDR_WIDTH-1:2]),
    .wvalid           (axil_wvalid),
    .wready           (axil_wready),
    .wdata            (axil_wdata),
    .wstrb            (axil_wstrb),
    .accept           (accept),
    .commit           (commit),
    .commit_word_addr (commit_word_addr),
    .commit_data      (commit_data),
    .commit_strb      (commit_strb)
  );

  // Byte offset bits carry no meaning for word-wide registers.
  assign unused_addr_lsbs = ^{axil_awaddr[1:0], axil_araddr[1:0]};

  assign w_idx = commit_word_addr[IDX_W-1:0];
  assign w_hit = commit_word_addr[AXIL_ADDR_WIDTH-3:IDX_W] == BASE_TAG;
  assign r_idx = axil_araddr[2 +: IDX_W];
  assign r_hit = axil_araddr[AXIL_ADDR_WIDTH-1:2+IDX_W] == BASE_TAG;

  assign axil_bvalid  = (wr_state == WR_RESP);
  assign axil_bresp   = bresp_q;
  assign axil_rvalid  = (rd_state == RD_RESP);
  assign axil_rresp   = rresp_q;
  assign axil_rdata   = rdata_q;
  assign axil_arready = reset_n && (rd_state == RD_IDLE);
  assign ctrl_out     = ctrl_q;

  // NOTE: the register array is reset because its contents drive fabric
  // directly; unlike a RAM it must come up at a known value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      bresp_q  <= OKAY;
      wr_pulse <= 1'b0;
      wr_index <= '0;
      ctrl_q   <= {REG_COUNT{RESET_VALUE}};
    end else begin
      wr_pulse <= 1'b0;
      unique case (wr_state)
        WR_IDLE, WR_PARTIAL: begin
          if (commit) begin
            wr_state <= WR_RESP;
            if (!w_hit) begin
              bresp_q <= DECERR;
            end else if (RO_MASK[w_idx]) begin
              bresp_q <= SLVERR;
            end else begin
              bresp_q  <= OKAY;
              wr_pulse <= 1'b1;
              wr_index <= w_idx;
              for (int k = 0; k < AXIL_DATA_WIDTH/8; k++) begin
                if (commit_strb[k]) ctrl_q[w_idx][8*k +: 8] <= commit_data[8*k +: 8];
              end
            end
          end else if (accept) begin
            wr_state <= WR_PARTIAL;
          end
        end
        WR_RESP: if (axil_bready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // ctrl_q is sampled before this edge's write lands, so a coincident read
  // returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (axil_arvalid) begin
        rd_state <= RD_RESP;
        if (!r_hit) begin
          rdata_q <= '0;
          rresp_q <= DECERR;
        end else if (RO_MASK[r_idx]) begin
          rdata_q <= status_in[r_idx];
          rresp_q <= OKAY;
        end else begin
          rdata_q <= ctrl_q[r_idx];
          rresp_q <= OKAY;
        end
      end
    end else if (axil_rready) begin
      rd_state <= RD_IDLE;
    end
  end

endmodule

// File: tb/tb_axil_register_bank.sv
// Self-checking bench for axil_register_bank: vector table, directed corner
// sequences and random traffic against an array-based reference model.
module tb_axil_register_bank;
  import axil_pkg::*;

  localparam int          REG_COUNT   = 16;
  localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
  localparam logic [15:0] RO_MASK     = 16'h0008;
  localparam logic [31:0] RESET_VALUE = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] axil_awaddr, axil_wdata, axil_araddr, axil_rdata;
  logic [3:0]  axil_wstrb;
  logic [1:0]  axil_bresp, axil_rresp;
  logic axil_awvalid, axil_awready, axil_wvalid, axil_wready, axil_bvalid, axil_bready;
  logic axil_arvalid, axil_arready, axil_rvalid, axil_rready;
  logic [REG_COUNT-1:0][31:0] ctrl_out, status_in;
  logic        wr_pulse;
  logic [3:0]  wr_index;

  axil_register_bank #(
    .REG_COUNT(REG_COUNT), .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK), .RESET_VALUE(RESET_VALUE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .axil_awaddr(axil_awaddr), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid),
    .axil_wready(axil_wready), .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid),
    .axil_bready(axil_bready), .axil_araddr(axil_araddr), .axil_arvalid(axil_arvalid),
    .axil_arready(axil_arready), .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
    .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
    .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain word array addressed by byte address arithmetic.
  logic [31:0] model [REG_COUNT];
  logic [31:0] status_val [REG_COUNT];

  function automatic void model_reset();
    for (int i = 0; i < REG_COUNT; i++) model[i] = RESET_VALUE;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, data, input logic [3:0] strb);
    int idx;
    if (addr / (REG_COUNT * 4) != BASE_ADDR / (REG_COUNT * 4)) return 2'b11;
    idx = int'((addr % (REG_COUNT * 4)) / 4);
    if (RO_MASK[idx]) return 2'b10;
    for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx;
    data = 32'h0;
    resp = 2'b11;
    if (addr / (REG_COUNT * 4) == BASE_ADDR / (REG_COUNT * 4)) begin
      idx  = int'((addr % (REG_COUNT * 4)) / 4);
      data = RO_MASK[idx] ? status_val[idx] : model[idx];
      resp = 2'b00;
    end
  endfunction

  task automatic check_regs(input string name);
    int mi = 0;
    for (int i = REG_COUNT - 1; i >= 0; i--) if (ctrl_out[i] !== model[i]) mi = i;
    check($sformatf("%s ctrl_out[%0d]", name, mi), ctrl_out[mi], model[mi]);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic do_write(input logic [31:0] addr, data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic pulse, output logic [3:0] idx,
                          output logic bv_at_commit, output logic pulse_after);
    logic aw_go, w_go;
    int n = 0;
    axil_awaddr = addr; axil_awvalid = 1'b1;
    axil_wdata = data; axil_wstrb = strb; axil_wvalid = 1'b1;
    axil_bready = 1'b1;
    while (axil_awvalid || axil_wvalid) begin
      aw_go = axil_awvalid && axil_awready;
      w_go  = axil_wvalid && axil_wready;
      @(negedge clk);
      if (aw_go) axil_awvalid = 1'b0;
      if (w_go)  axil_wvalid = 1'b0;
      n++;
      if (n > 50) begin
        check("write handshake timeout", 32'd0, 32'd1);
        axil_awvalid = 1'b0; axil_wvalid = 1'b0;
      end
    end
    pulse = wr_pulse; idx = wr_index; bv_at_commit = axil_bvalid;
    n = 0;
    while (!axil_bvalid && n < 50) begin @(negedge clk); n++; end
    if (!axil_bvalid) check("bvalid timeout", 32'd0, 32'd1);
    resp = axil_bresp;
    @(negedge clk);
    pulse_after = wr_pulse;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic go;
    int n = 0;
    axil_araddr = addr; axil_arvalid = 1'b1; axil_rready = 1'b1;
    while (axil_arvalid) begin
      go = axil_arready;
      @(negedge clk);
      if (go) axil_arvalid = 1'b0;
      n++;
      if (n > 50) begin check("read handshake timeout", 32'd0, 32'd1); axil_arvalid = 1'b0; end
    end
    n = 0;
    while (!axil_rvalid && n < 50) begin @(negedge clk); n++; end
    if (!axil_rvalid) check("rvalid timeout", 32'd0, 32'd1);
    data = axil_rdata; resp = axil_rresp;
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    bit          exp_pulse;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [1:0]  resp, exp_resp;
    logic [31:0] rd, exp_rd;
    logic [3:0]  idx;
    logic        pulse, bv, pulse_after;

    reset_n = 1'b0;
    axil_awaddr = '0; axil_awvalid = 1'b0; axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0;
    axil_bready = 1'b0; axil_araddr = '0; axil_arvalid = 1'b0; axil_rready = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) status_val[i] = $urandom;
    status_val[3] = 32'h1234_5678;
    for (int i = 0; i < REG_COUNT; i++) status_in[i] = status_val[i];
    model_reset();

    repeat (3) @(negedge clk);
    check("reset readys", {29'd0, axil_awready, axil_wready, axil_arready}, 32'd0);
    check("reset valids", {30'd0, axil_bvalid, axil_rvalid}, 32'd0);
    check("reset wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check_regs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 2'b11, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h0,         4'h0, 2'b11, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h1111_2222, 4'hF, 2'b10, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_001C, 32'hFFFF_FFFF, 4'h6, 2'b00, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_001C, 32'h0,         4'h0, 2'b00, 32'h5AFF_FF5A, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_003C, 32'h0000_0000, 4'h0, 2'b00, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_003F, 32'h0,         4'h0, 2'b00, 32'h5A5A_5A5A, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0008, 32'h0000_0000, 4'hF, 2'b11, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_000A, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h1000_0000, 32'h0,         4'h0, 2'b11, 32'h0, 1'b0});

    foreach (vecs[v]) begin
      if (vecs[v].is_read) begin
        do_read(vecs[v].addr, rd, resp);
        check($sformatf("vec%0d rresp", v), 32'(resp), 32'(vecs[v].exp_resp));
        check($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rdata);
      end else begin
        void'(model_write(vecs[v].addr, vecs[v].data, vecs[v].strb));
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse, idx, bv, pulse_after);
        check($sformatf("vec%0d bresp", v), 32'(resp), 32'(vecs[v].exp_resp));
        check($sformatf("vec%0d bvalid after commit", v), 32'(bv), 32'd1);
        check($sformatf("vec%0d wr_pulse", v), 32'(pulse), 32'(vecs[v].exp_pulse));
        check($sformatf("vec%0d wr_pulse width", v), 32'(pulse_after), 32'd0);
        if (vecs[v].exp_pulse)
          check($sformatf("vec%0d wr_index", v), 32'(idx), 32'(vecs[v].addr[5:2]));
        check_regs($sformatf("vec%0d", v));
      end
    end

    // W three cycles ahead of AW with a single-byte strobe.
    axil_wdata = 32'h0000_00AA; axil_wstrb = 4'h1; axil_wvalid = 1'b1; axil_bready = 1'b1;
    check("split wready open", 32'(axil_wready), 32'd1);
    @(negedge clk);
    axil_wvalid = 1'b0;
    check("split wready held", 32'(axil_wready), 32'd0);
    check("split awready open", 32'(axil_awready), 32'd1);
    check("split no early bvalid", 32'(axil_bvalid), 32'd0);
    repeat (2) @(negedge clk);
    axil_awaddr = 32'h0000_0004; axil_awvalid = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0;
    void'(model_write(32'h4, 32'hAA, 4'h1));
    check("split commit pulse", {27'd0, wr_pulse, wr_index}, {27'd0, 1'b1, 4'd1});
    check("split bvalid/bresp", {29'd0, axil_bvalid, axil_bresp}, {29'd0, 1'b1, 2'b00});
    @(negedge clk);
    check("split after B", {30'd0, axil_bvalid, wr_pulse}, 32'd0);
    check("split reg1", ctrl_out[1], 32'h5A5A_5AAA);

    // B backpressure: a second AW waits until one cycle after the B handshake.
    axil_bready = 1'b0;
    axil_awaddr = 32'h18; axil_awvalid = 1'b1;
    axil_wdata = 32'h66; axil_wstrb = 4'hF; axil_wvalid = 1'b1;
    @(negedge clk);
    void'(model_write(32'h18, 32'h66, 4'hF));
    axil_awaddr = 32'h20; axil_wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp B cycle %0d", i),
            {27'd0, axil_bvalid, axil_bresp, axil_awready, axil_wready}, {27'd0, 5'b1_00_00});
      @(negedge clk);
    end
    axil_bready = 1'b1;
    check("bp awready at B handshake", 32'(axil_awready), 32'd0);
    @(negedge clk);
    check("bp reopen", {30'd0, axil_bvalid, axil_awready}, {30'd0, 2'b01});
    @(negedge clk);
    axil_awvalid = 1'b0;
    check("bp second AW held", 32'(axil_awready), 32'd0);
    axil_wdata = 32'h77; axil_wvalid = 1'b1;
    @(negedge clk);
    axil_wvalid = 1'b0;
    void'(model_write(32'h20, 32'h77, 4'hF));
    check("bp second commit", {27'd0, axil_bvalid, wr_index}, {27'd0, 1'b1, 4'd8});
    @(negedge clk);
    check_regs("bp");

    // R backpressure.
    axil_rready = 1'b0; axil_araddr = 32'h18; axil_arvalid = 1'b1;
    @(negedge clk);
    axil_arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp R cycle %0d", i), {28'd0, axil_rvalid, axil_rresp, axil_arready},
            {28'd0, 4'b1_00_0});
      check($sformatf("bp R data %0d", i), axil_rdata, 32'h66);
      @(negedge clk);
    end
    axil_rready = 1'b1;
    @(negedge clk);
    check("bp R reopen", {30'd0, axil_rvalid, axil_arready}, {30'd0, 2'b01});

    // Read on the same edge as a write commit to the same register.
    do_write(32'h14, 32'h11, 4'hF, resp, pulse, idx, bv, pulse_after);
    void'(model_write(32'h14, 32'h11, 4'hF));
    axil_awaddr = 32'h14; axil_awvalid = 1'b1;
    axil_wdata = 32'h55; axil_wstrb = 4'hF; axil_wvalid = 1'b1; axil_bready = 1'b1;
    axil_araddr = 32'h14; axil_arvalid = 1'b1; axil_rready = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0; axil_wvalid = 1'b0; axil_arvalid = 1'b0;
    void'(model_write(32'h14, 32'h55, 4'hF));
    check("hazard both valid", {30'd0, axil_rvalid, axil_bvalid}, {30'd0, 2'b11});
    check("hazard old value", axil_rdata, 32'h11);
    @(negedge clk);
    do_read(32'h14, rd, resp);
    check("hazard new value", rd, 32'h55);

    // Random traffic against the model.
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | 32'h0100_0000;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        model_read(a, exp_rd, exp_resp);
        do_read(a, rd, resp);
        check($sformatf("rand%0d rd %h resp", t, a), 32'(resp), 32'(exp_resp));
        check($sformatf("rand%0d rd %h data", t, a), rd, exp_rd);
      end else begin
        exp_resp = model_write(a, d, s);
        do_write(a, d, s, resp, pulse, idx, bv, pulse_after);
        check($sformatf("rand%0d wr %h resp", t, a), 32'(resp), 32'(exp_resp));
        check($sformatf("rand%0d wr %h pulse", t, a), 32'(pulse), 32'(exp_resp == 2'b00));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_regs("random");

    // Reset while an AW is held and a read response is pending.
    axil_rready = 1'b0; axil_araddr = 32'h08; axil_arvalid = 1'b1;
    @(negedge clk);
    axil_arvalid = 1'b0;
    axil_awaddr = 32'h08; axil_awvalid = 1'b1; axil_bready = 1'b1;
    @(negedge clk);
    axil_awvalid = 1'b0;
    check("pre-reset state", {30'd0, axil_rvalid, axil_awready}, {30'd0, 2'b10});
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("midreset valids", {29'd0, axil_bvalid, axil_rvalid, wr_pulse}, 32'd0);
    check("midreset readys", {29'd0, axil_awready, axil_wready, axil_arready}, 32'd0);
    check_regs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    axil_rready = 1'b1;
    @(negedge clk);
    exp_resp = model_write(32'h14, 32'hABCD_0123, 4'hF);
    do_write(32'h14, 32'hABCD_0123, 4'hF, resp, pulse, idx, bv, pulse_after);
    check("post-reset bresp", 32'(resp), 32'(exp_resp));
    check("post-reset wr_index", {27'd0, pulse, idx}, {27'd0, 1'b1, 4'd5});
    check_regs("post-reset");
    do_read(32'h14, rd, resp);
    check("post-reset read", rd, 32'hABCD_0123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
